dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port request/acknowledge arbiter and access sequencer in front of the single-ported, unclocked DataMemory.
- Port A: load/store stage. Port B: debug/DMA loader.
- Grants one requester at a time with round-robin priority.
- Converts byte addresses to word indices and rejects misaligned or out-of-range accesses.
- Sequences the memory's level-sensitive write so `mem_rbar_w` pulses exactly once per write, with address and data already stable.

Parameters:
- DATA_W, 32, width of data and address buses.
- DEPTH_LOG2, 8, log2 of memory depth in words (256 words = 1024 bytes).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; held until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  DATA_W  port A byte address.
- a_wdata  in  DATA_W  port A write data.
- a_ack  out  1  port A one-cycle completion pulse.
- a_rdata  out  DATA_W  port A read data; valid while a_ack = 1.
- a_err  out  1  port A access rejected; valid while a_ack = 1.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err: same as port A, for port B.
- mem_addr  out  DATA_W  word index to DataMemory Address.
- mem_rbar_w  out  1  to DataMemory rbar_w; 1 = write.
- mem_wdata  out  DATA_W  to DataMemory WriteData.
- mem_rdata  in  DATA_W  from DataMemory ReadData.

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE; a_ack, b_ack, a_err, b_err, mem_rbar_w = 0; a_rdata, b_rdata, mem_addr, mem_wdata = 0; last_grant = B, so A wins the first tie.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - No requests: stay in IDLE.
  - Exactly one req high: grant that port.
  - Both high: grant the port not equal to last_grant.
  - On grant: latch we, addr, wdata and granted id; update last_grant; go to SETUP.
- Legality check, done on the latched address: legal = (addr[1:0] == 0) and (addr[DATA_W-1 : DEPTH_LOG2+2] == 0).
- SETUP: mem_addr = zero-extended addr[DEPTH_LOG2+1:2]; mem_wdata = latched wdata; mem_rbar_w = 0. Go to ACCESS.
- ACCESS:
  - mem_rbar_w = 1 only if we and legal; otherwise 0.
  - Legal read: capture mem_rdata into the granted port's rdata register.
  - Go to RESP.
- RESP:
  - mem_rbar_w = 0; mem_addr and mem_wdata unchanged.
  - Granted port: ack = 1, err = !legal.
  - rdata = captured value for a legal read; 0 for writes and errors.
  - Go to IDLE.
- Fixed latency: req sampled at edge 0 gives ack high in the cycle after edge 3; every access takes 4 cycles including the return to IDLE.
- Illegal access: no memory write ever occurs; latency is the same as a legal access.
- Handshake rules:
  - req, we, addr and wdata must be stable from req rise until ack.
  - The requester must drop req in the cycle after ack unless it intends a new transaction.
  - The ungranted port keeps waiting; its req is not dropped.
- Fairness: with both ports continuously requesting, grants alternate A, B, A, B…
- Starvation bound: a waiting port is served within 8 cycles.
- The non-granted port's ack, err and rdata stay 0.
- A req arriving during SETUP, ACCESS or RESP is ignored until the next IDLE.
- Reset mid-operation: the next edge forces IDLE and drops mem_rbar_w and both acks to 0. A write in ACCESS is cut at that edge; no ack is issued.

Test Plan:
- Reset, then port A writes 0xDEADBEEF to byte address 0x10 → mem_addr = 4; mem_rbar_w high for exactly one cycle (ACCESS); a_ack pulses in the 4th cycle after req; a_err = 0.
- Port A reads byte address 0x10 after that write → a_rdata = 0xDEADBEEF with a_ack. Port B reads byte address 0x20 with no prior write → b_rdata = 8 (init pattern).
- a_req and b_req asserted in the same cycle, held for 4 transactions each → grant order A, B, A, B; acks spaced 4 cycles apart; never both acks high.
- Port B writes to address 0x13 (misaligned), then to 0x400 (out of range) → b_ack with b_err = 1 and b_rdata = 0; mem_rbar_w stays 0; a follow-up read of word 4 is unchanged.
- reset asserted during the ACCESS cycle of a write → next cycle mem_rbar_w = 0, state IDLE, no a_ack. After release, a fresh read returns either the old or the new value; the bench checks only ack timing.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the unclocked DataMemory.
// Every access runs IDLE->SETUP->ACCESS->RESP; all outputs lag the state by one registered cycle.
module dmem_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [DATA_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_rbar_w,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int unsigned IDX_LO = 2;
    localparam int unsigned IDX_HI = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              gnt_b_q, gnt_b_d;
    logic              last_b_q, last_b_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic              a_err_q, a_err_d, b_err_q, b_err_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rbar_w_q, mem_rbar_w_d;

    logic              legal_c;
    logic              a_ok_c, b_ok_c, pick_b_c;
    logic [DATA_W-1:0] rsp_c;

    assign legal_c = (addr_q[1:0] == 2'b00) && (addr_q[DATA_W-1:IDX_HI+1] == '0);

    // A port whose ack is on the bus this cycle still shows req high; do not grant it twice.
    assign a_ok_c   = a_req && !a_ack_q;
    assign b_ok_c   = b_req && !b_ack_q;
    assign pick_b_c = b_ok_c && (!a_ok_c || !last_b_q);
    assign rsp_c    = (!we_q && legal_c) ? cap_q : '0;

    always_comb begin
        state_d      = state_q;
        gnt_b_d      = gnt_b_q;
        last_b_d     = last_b_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cap_d        = cap_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rbar_w_d = 1'b0;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_err_d      = 1'b0;
        b_err_d      = 1'b0;
        a_rdata_d    = '0;
        b_rdata_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (a_ok_c || b_ok_c) begin
                    gnt_b_d  = pick_b_c;
                    last_b_d = pick_b_c;
                    we_d     = pick_b_c ? b_we    : a_we;
                    addr_d   = pick_b_c ? b_addr  : a_addr;
                    wdata_d  = pick_b_c ? b_wdata : a_wdata;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                mem_addr_d  = DATA_W'(addr_q[IDX_HI:IDX_LO]);
                mem_wdata_d = wdata_q;
                state_d     = S_ACCESS;
            end
            S_ACCESS: begin
                mem_rbar_w_d = we_q && legal_c;
                if (!we_q && legal_c) begin
                    cap_d = mem_rdata;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (gnt_b_q) begin
                    b_ack_d   = 1'b1;
                    b_err_d   = !legal_c;
                    b_rdata_d = rsp_c;
                end else begin
                    a_ack_d   = 1'b1;
                    a_err_d   = !legal_c;
                    a_rdata_d = rsp_c;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            gnt_b_q      <= 1'b0;
            last_b_q     <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cap_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rbar_w_q <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_err_q      <= 1'b0;
            b_err_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            gnt_b_q      <= gnt_b_d;
            last_b_q     <= last_b_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cap_q        <= cap_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rbar_w_q <= mem_rbar_w_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_err_q      <= a_err_d;
            b_err_q      <= b_err_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign a_ack      = a_ack_q;
    assign b_ack      = b_ack_q;
    assign a_err      = a_err_q;
    assign b_err      = b_err_q;
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_rbar_w = mem_rbar_w_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-word DataMemory initialised to mem[i] = i.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rbar_w;

    logic [31:0] mem [256];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_pulses = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(32), .DEPTH_LOG2(8)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .mem_addr(mem_addr), .mem_rbar_w(mem_rbar_w),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    end

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_rbar_w) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            wr_pulses <= wr_pulses + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-port transaction: drives req just after an edge and waits (bounded) for the ack.
    task automatic run_txn(input string tag, input bit pb, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit exp_err, input logic [31:0] exp_rdata);
        int  lat;
        int  w0;
        bit  got;
        bit  other;
        w0 = wr_pulses;
        lat = 0;
        got = 1'b0;
        other = 1'b0;
        if (pb) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        while (!got && lat < 10) begin
            tick();
            lat++;
            if (pb ? (a_ack || a_err || a_rdata != 0) : (b_ack || b_err || b_rdata != 0)) other = 1'b1;
            if (pb ? b_ack : a_ack) got = 1'b1;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'd4);
        check_eq({tag, "_err"}, 32'(pb ? b_err : a_err), 32'(exp_err));
        check_eq({tag, "_rdata"}, pb ? b_rdata : a_rdata, exp_rdata);
        check_eq({tag, "_other"}, 32'(other), 32'd0);
        if (pb) b_req = 1'b0; else a_req = 1'b0;
        tick();
        check_eq({tag, "_wpulses"}, 32'(wr_pulses - w0), (we && !exp_err) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int cyc, na, nb, k, last_cyc, wr0;
        bit both, saw_ack;
        reset = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        tick(); tick();
        check_eq("rst_a_ack", 32'(a_ack), 32'd0);
        check_eq("rst_b_ack", 32'(b_ack), 32'd0);
        check_eq("rst_rbar_w", 32'(mem_rbar_w), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_a_rdata", a_rdata, 32'd0);
        reset = 1'b0;
        tick();

        run_txn("a_wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
        check_eq("a_wr10_mem_addr", mem_addr, 32'd4);
        run_txn("a_rd10", 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);
        run_txn("b_rd20", 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'd8);
        run_txn("b_rd3fc", 1'b1, 1'b0, 32'h3FC, 32'd0, 1'b0, 32'd255);

        // Both ports request together and hold for four transactions each; last grant was B.
        a_we = 0; a_addr = 32'h10; b_we = 0; b_addr = 32'h24;
        a_req = 1'b1; b_req = 1'b1;
        cyc = 0; na = 0; nb = 0; k = 0; last_cyc = -1; both = 1'b0;
        while ((na < 4 || nb < 4) && cyc < 60) begin
            tick();
            cyc++;
            if (a_ack && b_ack) both = 1'b1;
            if (a_ack || b_ack) begin
                check_eq($sformatf("rr_order%0d", k), 32'(b_ack), 32'(k % 2));
                check_eq($sformatf("rr_rdata%0d", k), b_ack ? b_rdata : a_rdata,
                         b_ack ? 32'd9 : 32'hDEADBEEF);
                if (last_cyc >= 0) check_eq($sformatf("rr_gap%0d", k), 32'(cyc - last_cyc), 32'd4);
                last_cyc = cyc;
                k++;
                if (a_ack) begin na++; if (na == 4) a_req = 1'b0; end
                if (b_ack) begin nb++; if (nb == 4) b_req = 1'b0; end
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        check_eq("rr_count_a", 32'(na), 32'd4);
        check_eq("rr_count_b", 32'(nb), 32'd4);
        check_eq("rr_both_ack", 32'(both), 32'd0);
        tick();

        run_txn("b_wr13", 1'b1, 1'b1, 32'h13, 32'h12345678, 1'b1, 32'd0);
        run_txn("b_wr400", 1'b1, 1'b1, 32'h400, 32'h87654321, 1'b1, 32'd0);
        run_txn("a_rd10_post", 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);
        run_txn("a_rd400", 1'b0, 1'b0, 32'h400, 32'd0, 1'b1, 32'd0);

        // Reset lands on the ACCESS cycle of a write.
        wr0 = wr_pulses;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'h55;
        tick(); tick();
        reset = 1'b1;
        tick();
        check_eq("rstmid_rbar_w", 32'(mem_rbar_w), 32'd0);
        check_eq("rstmid_a_ack", 32'(a_ack), 32'd0);
        reset = 1'b0;
        a_req = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_ack || b_ack) saw_ack = 1'b1;
        end
        check_eq("rstmid_no_ack", 32'(saw_ack), 32'd0);
        check_eq("rstmid_no_write", 32'(wr_pulses - wr0), 32'd0);
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
        cyc = 0; saw_ack = 1'b0;
        while (!saw_ack && cyc < 10) begin
            tick();
            cyc++;
            if (a_ack) saw_ack = 1'b1;
        end
        a_req = 1'b0;
        check_eq("rstmid_rd_lat", 32'(cyc), 32'd4);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
